// File: rtl/vga_bounce_engine.sv
// VGA pixel engine: self-timed raster, one bouncing box over a flat background.
// Ports: clk_pix/rst_pix_n, enable/speed motion controls, registered sync/de/frame/rgb outputs.
module vga_bounce_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int BOX_SIZE = 200,
  parameter logic [COLOR_W-1:0] BG_R  = COLOR_W'(1),
  parameter logic [COLOR_W-1:0] BG_G  = COLOR_W'(3),
  parameter logic [COLOR_W-1:0] BG_B  = COLOR_W'(7),
  parameter logic [COLOR_W-1:0] BOX_R = '1,
  parameter logic [COLOR_W-1:0] BOX_G = '1,
  parameter logic [COLOR_W-1:0] BOX_B = '1
) (
  input  logic               clk_pix,
  input  logic               rst_pix_n,
  input  logic               enable,
  input  logic [3:0]         speed,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic               o_frame,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] HT_M1 = 16'(H_TOTAL - 1);
  localparam logic [15:0] VT_M1 = 16'(V_TOTAL - 1);
  localparam logic [15:0] HA    = 16'(H_ACTIVE);
  localparam logic [15:0] VA    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_LO = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_HI = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_LO = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_HI = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [16:0] BOX17 = 17'(BOX_SIZE);
  localparam logic [16:0] XLIM  = 17'(H_ACTIVE - BOX_SIZE);
  localparam logic [16:0] YLIM  = 17'(V_ACTIVE - BOX_SIZE);
  localparam logic [15:0] BX0   = 16'((H_ACTIVE - BOX_SIZE) / 2);
  localparam logic [15:0] BY0   = 16'((V_ACTIVE - BOX_SIZE) / 2);

  // {new_dir, new_pos}; clamps to the wall and reverses on contact
  function automatic logic [16:0] step_axis(
    input logic [15:0] pos,
    input logic        dir,
    input logic [3:0]  spd,
    input logic [16:0] lim
  );
    logic [16:0] p;
    logic [16:0] s;
    p = {1'b0, pos};
    s = {13'd0, spd};
    if (dir) begin
      if (p + s >= lim) return {1'b0, lim[15:0]};
      return {1'b1, 16'(p + s)};
    end
    if (p <= s) return {1'b1, 16'd0};
    return {1'b0, 16'(p - s)};
  endfunction

  logic [15:0] sx_q, sx_d;
  logic [15:0] sy_q, sy_d;
  logic [15:0] bx_q, bx_d;
  logic [15:0] by_q, by_d;
  logic        dx_q, dx_d;
  logic        dy_q, dy_d;

  logic de0, hs0, vs0, tick0, hit0;
  logic de1_q, hs1_q, vs1_q, tick1_q, hit1_q;

  logic               hsync_q, vsync_q, de2_q, frame_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  logic [COLOR_W-1:0] red_d, green_d, blue_d;

  always_comb begin
    sx_d = sx_q + 16'd1;
    sy_d = sy_q;
    if (sx_q == HT_M1) begin
      sx_d = '0;
      sy_d = (sy_q == VT_M1) ? 16'd0 : sy_q + 16'd1;
    end
  end

  always_comb begin
    de0   = (sx_q < HA) && (sy_q < VA);
    hs0   = (sx_q >= HS_LO) && (sx_q < HS_HI);
    vs0   = (sy_q >= VS_LO) && (sy_q < VS_HI);
    tick0 = (sx_q == 16'd0) && (sy_q == VA);
    hit0  = (sx_q >= bx_q)
         && ({1'b0, sx_q} < {1'b0, bx_q} + BOX17)
         && (sy_q >= by_q)
         && ({1'b0, sy_q} < {1'b0, by_q} + BOX17);
  end

  // Moves only on the blank-line tick, so a frame never tears
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (tick0 && enable) begin
      {dx_d, bx_d} = step_axis(bx_q, dx_q, speed, XLIM);
      {dy_d, by_d} = step_axis(by_q, dy_q, speed, YLIM);
    end
  end

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (de1_q) begin
      red_d   = hit1_q ? BOX_R : BG_R;
      green_d = hit1_q ? BOX_G : BG_G;
      blue_d  = hit1_q ? BOX_B : BG_B;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      bx_q    <= BX0;
      by_q    <= BY0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      tick1_q <= 1'b0;
      hit1_q  <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de2_q   <= 1'b0;
      frame_q <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      de1_q   <= de0;
      hs1_q   <= hs0;
      vs1_q   <= vs0;
      tick1_q <= tick0;
      hit1_q  <= hit0;
      hsync_q <= hs1_q ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs1_q ? SYNC_POL : ~SYNC_POL;
      de2_q   <= de1_q;
      frame_q <= tick1_q;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_de    = de2_q;
  assign o_frame = frame_q;
  assign o_red   = red_q;
  assign o_green = green_q;
  assign o_blue  = blue_q;

endmodule

// File: tb/tb_vga_bounce_engine.sv
// Bench for vga_bounce_engine on a shrunken raster.
// Frame-level reference model plus bounce, timing and reset scenarios.
module tb_vga_bounce_engine;

  localparam int HA = 32, HF = 2, HS = 4, HB = 2;
  localparam int VA = 24, VF = 2, VS = 2, VB = 2;
  localparam int BOX = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] speed = 4'd0;
  logic       o_hsync, o_vsync, o_de, o_frame;
  logic [3:0] o_red, o_green, o_blue;

  vga_bounce_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_W(4), .BOX_SIZE(BOX)
  ) dut (
    .clk_pix(clk), .rst_pix_n(rst_n),
    .enable(enable), .speed(speed),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_de(o_de), .o_frame(o_frame),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int k;
  int mbx, mby;
  bit mdx, mdy;

  int    err_cnt;
  string err_msg;
  int    hs_cnt, vs_cnt, de_cnt, fr_cnt;
  bit    obs_found;
  int    obs_x, obs_y, last_x, last_y;
  logic [11:0] cap_left, cap_right, cap_blank;

  task automatic model_reset();
    k   = 0;
    mbx = (HA - BOX) / 2;
    mby = (VA - BOX) / 2;
    mdx = 1'b1;
    mdy = 1'b1;
  endtask

  task automatic move_axis(inout int pos, inout bit dir, input int lim);
    int s;
    s = int'(speed);
    if (dir) begin
      if (pos + s >= lim) begin pos = lim; dir = 1'b0; end
      else pos = pos + s;
    end else begin
      if (pos <= s) begin pos = 0; dir = 1'b1; end
      else pos = pos - s;
    end
  endtask

  task automatic clear_stats();
    err_cnt = 0; err_msg = "";
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fr_cnt = 0;
    obs_found = 1'b0; obs_x = -1; obs_y = -1;
    last_x = -1; last_y = -1;
    cap_left = 'x; cap_right = 'x; cap_blank = 'x;
  endtask

  task automatic check_pixel(input int p);
    int sx, sy;
    bit ede, ehs, evs, efr, ehit;
    logic [3:0] er, eg, eb;
    logic [15:0] got, exp;
    sx   = p % HT;
    sy   = (p / HT) % VT;
    ede  = (sx < HA) && (sy < VA);
    ehs  = (sx >= HA + HF) && (sx < HA + HF + HS);
    evs  = (sy >= VA + VF) && (sy < VA + VF + VS);
    efr  = (sx == 0) && (sy == VA);
    ehit = (sx >= mbx) && (sx < mbx + BOX) && (sy >= mby) && (sy < mby + BOX);
    er = !ede ? 4'h0 : (ehit ? 4'hF : 4'h1);
    eg = !ede ? 4'h0 : (ehit ? 4'hF : 4'h3);
    eb = !ede ? 4'h0 : (ehit ? 4'hF : 4'h7);
    exp = {~ehs, ~evs, ede, efr, er, eg, eb};
    got = {o_hsync, o_vsync, o_de, o_frame, o_red, o_green, o_blue};
    if (got !== exp) begin
      if (err_cnt == 0)
        err_msg = $sformatf("px(%0d,%0d) got %h want %h", sx, sy, got, exp);
      err_cnt++;
    end
    if (o_hsync === 1'b0) hs_cnt++;
    if (o_vsync === 1'b0) vs_cnt++;
    if (o_de === 1'b1) de_cnt++;
    if (o_frame === 1'b1) fr_cnt++;
    if (o_de === 1'b1 && {o_red, o_green, o_blue} === 12'hFFF) begin
      if (!obs_found) begin obs_found = 1'b1; obs_x = sx; obs_y = sy; end
      last_x = sx; last_y = sy;
    end
    if (sx == mbx - 1 && sy == mby) cap_left = {o_red, o_green, o_blue};
    if (sx == mbx + BOX && sy == mby) cap_right = {o_red, o_green, o_blue};
    if (sx == HA + 1 && sy == 0) cap_blank = {o_red, o_green, o_blue};
    if (efr && enable) begin
      move_axis(mbx, mdx, HA - BOX);
      move_axis(mby, mdy, VA - BOX);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (k >= 2) check_pixel(k - 2);
  endtask

  task automatic run_frame(input string name);
    clear_stats();
    repeat (FRAME) step();
    tests++;
    if (err_cnt !== 0) begin
      fails++;
      $display("FAIL %s: %0d bad pixels, first %s", name, err_cnt, err_msg);
    end
  endtask

  task automatic check_origin(input string name, input int ex, input int ey);
    tests++;
    if (!obs_found || obs_x !== ex || obs_y !== ey) begin
      fails++;
      $display("FAIL %s: box origin (%0d,%0d) found=%0b, want (%0d,%0d)",
               name, obs_x, obs_y, obs_found, ex, ey);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_hsync, o_vsync} !== 2'b11) begin
      fails++;
      $display("FAIL reset_sync: got %b want 11", {o_hsync, o_vsync});
    end
    tests++;
    if ({o_de, o_frame} !== 2'b00) begin
      fails++;
      $display("FAIL reset_de_frame: got %b want 00", {o_de, o_frame});
    end
    tests++;
    if ({o_red, o_green, o_blue} !== 12'h000) begin
      fails++;
      $display("FAIL reset_rgb: got %h want 000", {o_red, o_green, o_blue});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_static_frame();
    enable = 1'b0;
    speed  = 4'd9;
    run_frame("static_frame");
    tests++;
    if (hs_cnt !== VT * HS) begin
      fails++;
      $display("FAIL hsync_low: got %0d want %0d", hs_cnt, VT * HS);
    end
    tests++;
    if (vs_cnt !== VS * HT) begin
      fails++;
      $display("FAIL vsync_low: got %0d want %0d", vs_cnt, VS * HT);
    end
    tests++;
    if (de_cnt !== HA * VA) begin
      fails++;
      $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA);
    end
    tests++;
    if (fr_cnt !== 1) begin
      fails++;
      $display("FAIL frame_pulses: got %0d want 1", fr_cnt);
    end
    check_origin("static_origin", 13, 9);
    tests++;
    if (last_x !== 18 || last_y !== 14) begin
      fails++;
      $display("FAIL static_corner: got (%0d,%0d) want (18,14)", last_x, last_y);
    end
    tests++;
    if (cap_left !== 12'h137 || cap_right !== 12'h137) begin
      fails++;
      $display("FAIL static_edges: got %h/%h want 137/137", cap_left, cap_right);
    end
    tests++;
    if (cap_blank !== 12'h000) begin
      fails++;
      $display("FAIL static_blank: got %h want 000", cap_blank);
    end
  endtask

  task automatic test_step_and_hold();
    enable = 1'b1;
    speed  = 4'd4;
    run_frame("step_frame0");
    check_origin("step_origin0", 13, 9);
    speed = 4'd0;
    for (int i = 0; i < 3; i++) begin
      run_frame("hold_frame");
      check_origin("hold_origin", 17, 13);
    end
  endtask

  task automatic test_bounce();
    int ex[9] = '{13, 17, 21, 25, 26, 22, 7, 0, 15};
    int ey[9] = '{9, 13, 17, 18, 14, 10, 0, 15, 18};
    do_reset();
    enable = 1'b1;
    speed  = 4'd4;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) speed = 4'd15;
      run_frame($sformatf("bounce_frame%0d", i));
      check_origin($sformatf("bounce_origin%0d", i), ex[i], ey[i]);
    end
  endtask

  task automatic test_random();
    int sx0, sy0;
    for (int i = 0; i < 8; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      speed  = 4'($urandom_range(0, 15));
      sx0 = mbx;
      sy0 = mby;
      run_frame($sformatf("random_frame%0d", i));
      check_origin($sformatf("random_origin%0d", i), sx0, sy0);
    end
  endtask

  task automatic test_midreset();
    int first;
    enable = 1'b1;
    speed  = 4'd7;
    repeat (10 * HT + 20) step();
    tests++;
    if (o_de !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre_de: got %b want 1", o_de);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({o_hsync, o_vsync, o_de, o_frame, o_red, o_green, o_blue} !== 16'hC000) begin
      fails++;
      $display("FAIL midreset_outputs: got %h want c000",
               {o_hsync, o_vsync, o_de, o_frame, o_red, o_green, o_blue});
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_stats();
    first = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (first < 0 && o_hsync === 1'b0) first = i;
    end
    tests++;
    if (first !== HA + HF + 2) begin
      fails++;
      $display("FAIL midreset_hsync: first low after %0d clocks, want %0d",
               first, HA + HF + 2);
    end
    while ((k - 1) % FRAME != 0) step();
    run_frame("post_reset_frame");
    check_origin("post_reset_origin", 13, 9);
  endtask

  initial begin
    test_reset();
    test_static_frame();
    test_step_and_hold();
    test_bounce();
    test_random();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_bounce_engine.md
Name: vga_bounce_engine

Overview:
- Parametrised VGA pixel engine. It generates its own display timing, renders one square box over a flat background, and moves the box every frame with wall bounces.
- Generalises the fixed 640x480 static-square path: timing, colour depth, box size and colours are parameters, and position and motion are stateful.
- Sits between the pixel-clock PLL output and the board VGA pins.
- All outputs are registered and pipeline-aligned, so sync and colour leave the block on the same cycle.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low)
COLOR_W, 4, bits per colour channel
BOX_SIZE, 200, box edge length in pixels; must be less than both H_ACTIVE and V_ACTIVE
BG_R/BG_G/BG_B, 1/3/7, background colour
BOX_R/BOX_G/BOX_B, all-ones, box colour

Ports:
clk_pix  input  1  pixel clock (25 MHz for defaults)
rst_pix_n  input  1  asynchronous active-low reset
enable  input  1  motion enable; sampled at the frame tick
speed  input  4  pixels moved per frame per axis; sampled at the frame tick
o_hsync  output  1  horizontal sync, polarity set by SYNC_POL
o_vsync  output  1  vertical sync, polarity set by SYNC_POL
o_de  output  1  data enable (active-area pixel)
o_frame  output  1  one-cycle pulse, aligned with the outputs, at the first blank line
o_red  output  COLOR_W  red
o_green  output  COLOR_W  green
o_blue  output  COLOR_W  blue

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800); V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).
- Stage 0, counters:
  - sx counts 0..H_TOTAL-1 and wraps to 0.
  - sy increments when sx wraps, counts 0..V_TOTAL-1 and wraps to 0.
  - Both counters are 16 bits.
- Stage 0 combinational decode:
  - de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
  - hs asserted when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted when V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC.
  - tick = (sx == 0 && sy == V_ACTIVE).
- Stage 1 registers de, hs, vs and tick, plus hit = (bx <= sx < bx+BOX_SIZE) && (by <= sy < by+BOX_SIZE). The box interval is half-open.
- Stage 2 registers every output:
  - colour = box colour if hit, else background colour;
  - colour forced to 0 when de is low;
  - syncs driven at SYNC_POL when asserted, ~SYNC_POL otherwise.
- Latency: outputs reflect counter position (sx, sy) exactly 2 clk_pix cycles later, and sync/de/colour are mutually aligned.
- Box position registers bx and by (16 bits each) with direction bits dx and dy (1 = increasing):
  - They update only in the cycle where stage-0 tick is high and enable is 1.
  - Because the update happens in vertical blank, it is never visible mid-frame.
  - With speed = 0, position holds.
- X update:
  - If dx = 1 and bx + speed >= H_ACTIVE - BOX_SIZE: bx <= H_ACTIVE - BOX_SIZE, dx <= 0.
  - Otherwise, if dx = 1: bx <= bx + speed.
  - If dx = 0 and bx <= speed: bx <= 0, dx <= 1.
  - Otherwise, if dx = 0: bx <= bx - speed.
  - Y follows the same rule with V_ACTIVE and dy.
  - Arithmetic uses 17-bit intermediates, so there is no wrap.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - sx = sy = 0; pipeline registers cleared.
  - o_de = 0, o_frame = 0, colours = 0, syncs = ~SYNC_POL (deasserted).
  - bx = (H_ACTIVE - BOX_SIZE)/2 (220), by = (V_ACTIVE - BOX_SIZE)/2 (140), dx = dy = 1.
  - After reset release, timing restarts at (0, 0); first valid pixel output comes 2 cycles later.

Test Plan:
1. Reset, then release; measure the outputs (defaults) -> o_hsync low for exactly 96 clocks, period 800; o_vsync low for 2 lines (1600 clocks), period 525 lines; o_de high 640 clocks/line for 480 lines; o_frame exactly once per 420000 clocks.
2. First frame, enable = 0 -> pixel (220,140) = F/F/F; (219,140) = 1/3/7; (419,339) = F/F/F; (420,140) = 1/3/7; any blank pixel = 0/0/0. Check each pixel 2 cycles after the counter reaches it.
3. enable = 1, speed = 4, one frame tick -> next frame box origin (224,144); speed = 0 -> origin unchanged across 3 frames.
4. enable = 1, speed = 4, run 35 ticks -> by = 280 and dy = 0; the next tick gives by = 276. After 55 ticks, bx = 440 and dx = 0; the next tick gives bx = 436.
5. Bounce at the low wall: force the box moving left with speed = 15 from bx = 10 -> bx = 0 and dx = 1; the next tick gives bx = 15.
6. Assert rst_pix_n low mid-active-line (sx = 300, sy = 200) -> outputs immediately at reset values and box back at (220,140); after release, first o_hsync assertion comes after 656+2 clocks.
